// File: rtl/hd_loader_pkg.sv
// Shared HardDisk loader definitions: field widths used by every HardDisk
// client and the loader FSM state encoding.
package hd_loader_pkg;

    localparam int unsigned HD_SECTOR_W = 4;
    localparam int unsigned HD_TRACK_W  = 10;
    localparam int unsigned WORD_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } ld_state_e;

endpackage

// File: rtl/hd_program_loader_if.sv
// Disk-read and instruction-memory write bus of the program loader.
//   master (loader): drives hd_sector/hd_track/hd_flag and imem_addr/imem_data/imem_we,
//                    receives hd_data.
//   slave  (disk+imem side): the mirror image.
interface hd_program_loader_if
    import hd_loader_pkg::*;
#(
    parameter int unsigned IMEM_AW = 10
);
    logic [HD_SECTOR_W-1:0] hd_sector;
    logic [HD_TRACK_W-1:0]  hd_track;
    logic                   hd_flag;
    logic [WORD_W-1:0]      hd_data;
    logic [IMEM_AW-1:0]     imem_addr;
    logic [WORD_W-1:0]      imem_data;
    logic                   imem_we;

    modport master (
        output hd_sector, hd_track, hd_flag, imem_addr, imem_data, imem_we,
        input  hd_data
    );

    modport slave (
        input  hd_sector, hd_track, hd_flag, imem_addr, imem_data, imem_we,
        output hd_data
    );
endinterface

// File: rtl/hd_read_timer.sv
// Disk read-latency timer: cleared by load, counts up while en, and raises
// strobe_c on the last wait cycle (count == READ_WAIT-1).
//   clock, reset : system clock, async active-high reset
//   load         : clear the count
//   en           : advance the count
//   strobe_c     : combinational sample strobe
module hd_read_timer #(
    parameter int unsigned READ_WAIT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic strobe_c
);
    localparam int unsigned CNT_W = (READ_WAIT > 2) ? $clog2(READ_WAIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign strobe_c = en && (cnt_q == CNT_W'(READ_WAIT - 1));
endmodule

// File: rtl/hd_program_loader.sv
// Program loader: copies instr_count words of one disk sector (track 0..count-1)
// into instruction memory starting at imem_base, holding busy while it works.
//   clock, reset             : system clock, async active-high reset
//   start/sector_sel/instr_count/imem_base : load request, sampled in IDLE only
//   bus (master)             : disk read address/data and imem write port
//   busy                     : accepted start until DONE exits
//   done / err               : 1-cycle pulses (finished / start rejected)
//   checksum                 : XOR of words written this load, present only when
//                              HD_LOADER_CHECKSUM_EN is defined
module hd_program_loader
    import hd_loader_pkg::*;
#(
    parameter int unsigned MAX_INSTR = 250,
    parameter int unsigned IMEM_AW   = 10,
    parameter int unsigned READ_WAIT = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [HD_SECTOR_W-1:0] sector_sel,
    input  logic [HD_TRACK_W-1:0]  instr_count,
    input  logic [IMEM_AW-1:0]     imem_base,
    hd_program_loader_if.master    bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef HD_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]      checksum
`endif
);
    ld_state_e              state_q, state_d;
    logic [HD_TRACK_W-1:0]  index_q, index_d;
    logic [HD_SECTOR_W-1:0] sector_q, sector_d;
    logic [HD_TRACK_W-1:0]  count_q, count_d;
    logic [IMEM_AW-1:0]     base_q, base_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic [HD_SECTOR_W-1:0] hd_sector_q, hd_sector_d;
    logic [HD_TRACK_W-1:0]  hd_track_q, hd_track_d;
    logic [IMEM_AW-1:0]     imem_addr_q, imem_addr_d;
    logic                   imem_we_q, imem_we_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
`ifdef HD_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]      checksum_q, checksum_d;
`endif
    logic                   strobe_c;

    hd_read_timer #(.READ_WAIT(READ_WAIT)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (state_q == ST_ISSUE),
        .en       (state_q == ST_WAIT),
        .strobe_c (strobe_c)
    );

    // Next state, datapath and registered outputs (outputs follow the next state)
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        sector_d    = sector_q;
        count_d     = count_q;
        base_d      = base_q;
        data_d      = data_q;
        hd_sector_d = hd_sector_q;
        hd_track_d  = hd_track_q;
        imem_addr_d = imem_addr_q;
        err_d       = 1'b0;
`ifdef HD_LOADER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (instr_count == '0) begin
                        state_d = ST_DONE;
`ifdef HD_LOADER_CHECKSUM_EN
                        checksum_d = '0;
`endif
                    end else if (instr_count > HD_TRACK_W'(MAX_INSTR)) begin
                        err_d = 1'b1;
                    end else begin
                        sector_d = sector_sel;
                        count_d  = instr_count;
                        base_d   = imem_base;
                        index_d  = '0;
                        state_d  = ST_ISSUE;
`ifdef HD_LOADER_CHECKSUM_EN
                        checksum_d = '0;
`endif
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (strobe_c) begin
                    data_d      = bus.hd_data;
                    imem_addr_d = base_q + IMEM_AW'(index_q);
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
`ifdef HD_LOADER_CHECKSUM_EN
                checksum_d = checksum_q ^ data_q;
`endif
                if (index_q == count_q - HD_TRACK_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + HD_TRACK_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Disk address is loaded on entry to ISSUE and then held
        if (state_d == ST_ISSUE) begin
            hd_sector_d = sector_d;
            hd_track_d  = index_d;
        end
        imem_we_d = (state_d == ST_WRITE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            sector_q    <= '0;
            count_q     <= '0;
            base_q      <= '0;
            data_q      <= '0;
            hd_sector_q <= '0;
            hd_track_q  <= '0;
            imem_addr_q <= '0;
            imem_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef HD_LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            sector_q    <= sector_d;
            count_q     <= count_d;
            base_q      <= base_d;
            data_q      <= data_d;
            hd_sector_q <= hd_sector_d;
            hd_track_q  <= hd_track_d;
            imem_addr_q <= imem_addr_d;
            imem_we_q   <= imem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef HD_LOADER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign bus.hd_sector = hd_sector_q;
    assign bus.hd_track  = hd_track_q;
    assign bus.hd_flag   = 1'b0;   // loader only ever reads the disk
    assign bus.imem_addr = imem_addr_q;
    assign bus.imem_data = data_q;
    assign bus.imem_we   = imem_we_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
`ifdef HD_LOADER_CHECKSUM_EN
    assign checksum      = checksum_q;
`endif
endmodule

// File: tb/tb_hd_program_loader.sv
// Scoreboard bench for hd_program_loader: loads push expected imem writes,
// a negedge monitor pops and compares each write it sees.
module tb_hd_program_loader;
    localparam int unsigned AW = 10;
    localparam int unsigned RW = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [3:0]     sector_sel = '0;
    logic [9:0]     instr_count = '0;
    logic [AW-1:0]  imem_base = '0;
    logic           busy, done, err;
`ifdef HD_LOADER_CHECKSUM_EN
    logic [31:0]    checksum;
`endif

    int  errors = 0;
    int  checks = 0;
    int  n_we   = 0;
    int  n_err  = 0;
    wr_t exp_q[$];

    hd_program_loader_if #(.IMEM_AW(AW)) bus ();

    hd_program_loader #(.MAX_INSTR(250), .IMEM_AW(AW), .READ_WAIT(RW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .sector_sel  (sector_sel),
        .instr_count (instr_count),
        .imem_base   (imem_base),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef HD_LOADER_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clock = ~clock;

    // Disk contents: sector 3 = 0x1000_0000+t, sector 5 = three fixed words
    function automatic logic [31:0] disk_word(input logic [3:0] s, input logic [9:0] t);
        logic [31:0] w;
        if (s == 4'd3) begin
            w = 32'h1000_0000 + {22'd0, t};
        end else if (s == 4'd5) begin
            case (t)
                10'd0:   w = 32'hA5A5_A5A5;
                10'd1:   w = 32'h0F0F_0F0F;
                10'd2:   w = 32'hFFFF_0000;
                default: w = 32'h0;
            endcase
        end else begin
            w = {12'hC0D, s, 6'd0, t};
        end
        return w;
    endfunction

    assign bus.hd_data = disk_word(bus.hd_sector, bus.hd_track);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every imem write is popped from the scoreboard and compared
    always @(negedge clock) begin
        if (!reset && bus.imem_we) begin
            wr_t e;
            n_we++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected no write",
                         bus.imem_addr, bus.imem_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.imem_addr !== e.addr || bus.imem_data !== e.data) begin
                    errors++;
                    $display("FAIL imem_write: got addr=%h data=%h expected addr=%h data=%h",
                             bus.imem_addr, bus.imem_data, e.addr, e.data);
                end
            end
            checks++;
            if (bus.hd_flag !== 1'b0) begin
                errors++;
                $display("FAIL hd_flag: got %b expected 0", bus.hd_flag);
            end
        end
        if (!reset && err) n_err++;
    end

    task automatic push_exp(input logic [3:0] s, input logic [AW-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = b + AW'(i);
            e.data = disk_word(s, 10'(i));
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; start is sampled by the next edge
    task automatic pulse_start(input logic [3:0] s, input logic [9:0] c, input logic [AW-1:0] b);
        sector_sel  = s;
        instr_count = c;
        imem_base   = b;
        start       = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Cycle 1 is the cycle in which start is high
    task automatic wait_done(input string name, output int cyc);
        cyc = 2;
        while (!done && cyc < 3000) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
        end
    endtask

    task automatic run_load(input string name, input logic [3:0] s, input int c,
                            input logic [AW-1:0] b);
        int cyc;
        int we0;
        we0 = n_we;
        push_exp(s, b, c);
        pulse_start(s, 10'(c), b);
        wait_done(name, cyc);
        check({name, "_latency"}, 32'(cyc), 32'(1 + c * (2 + RW) + 1));
        check({name, "_busy_at_done"}, 32'(busy), 32'd1);
        @(posedge clock); #1;
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_done_1cycle"}, 32'(done), 32'd0);
        check({name, "_nwrites"}, 32'(n_we - we0), 32'(c));
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        int we0;
        int guard;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_track", 32'(bus.hd_track), 32'd0);
        check("rst_sector", 32'(bus.hd_sector), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_flag", 32'(bus.hd_flag), 32'd0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;

        // Basic load: 0x010..0x013 <- 0x1000_0000..0x1000_0003, done in cycle 18
        run_load("basic", 4'd3, 4, 10'h010);

        // Zero count: done in cycle 2, no writes
        run_load("zero", 4'd3, 0, 10'h050);

        // Over-limit count: err pulse, never busy
        we0 = n_we;
        pulse_start(4'd3, 10'd251, 10'h000);
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        check("err_1cycle", 32'(err), 32'd0);
        check("err_busy2", 32'(busy), 32'd0);
        repeat (4) begin @(posedge clock); #1; end
        check("err_nwrites", 32'(n_we - we0), 32'd0);
        check("err_count", 32'(n_err), 32'd1);

        // Address wrap: 0x3FE,0x3FF,0x000,0x001
        run_load("wrap", 4'd7, 4, 10'h3FE);

        // Largest legal count is accepted
        run_load("max", 4'd9, 250, 10'h300);

        // Start re-pulsed while busy and on the done cycle: ignored
        we0 = n_we;
        push_exp(4'd3, 10'h200, 4);
        pulse_start(4'd3, 10'd4, 10'h200);
        repeat (4) begin @(posedge clock); #1; end
        pulse_start(4'd5, 10'd2, 10'h100);
        wait_done("repulse", cyc);
        sector_sel = 4'd5; instr_count = 10'd2; imem_base = 10'h100; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("repulse_idle", 32'(busy), 32'd0);
        repeat (12) begin @(posedge clock); #1; end
        check("repulse_busy", 32'(busy), 32'd0);
        check("repulse_nwrites", 32'(n_we - we0), 32'd4);
        check("repulse_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-load after the second word
        we0 = n_we;
        push_exp(4'd3, 10'h040, 2);
        pulse_start(4'd3, 10'd4, 10'h040);
        guard = 0;
        while ((n_we - we0) < 2 && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check("rst_mid_reach2", 32'(n_we - we0), 32'd2);
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_we", 32'(bus.imem_we), 32'd0);
        check("rst_mid_track", 32'(bus.hd_track), 32'd0);
        check("rst_mid_sector", 32'(bus.hd_sector), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        repeat (10) begin @(posedge clock); #1; end
        check("rst_mid_nwrites", 32'(n_we - we0), 32'd2);
        check("rst_mid_sb_empty", 32'(exp_q.size()), 32'd0);

        // Load after reset works normally
        run_load("post_rst", 4'd3, 3, 10'h100);

`ifdef HD_LOADER_CHECKSUM_EN
        // A5A5A5A5 ^ 0F0F0F0F = AAAAAAAA; ^ FFFF0000 = 5555AAAA
        run_load("csum", 4'd5, 3, 10'h020);
        check("csum_value", checksum, 32'h5555_AAAA);
        run_load("csum_zero", 4'd5, 0, 10'h020);
        check("csum_zero_value", checksum, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish before 400000");
        $fatal(1);
    end
endmodule
